ca_row_mem_sched: RTL and testbench

// - Arbitrates one single-port row RAM (one WIDTH-bit word per automaton generation row) between two requesters:
//   - the VGA display path, which has priority;
//   - the automaton generation engine.
// - Driven by the registered vga_sync outputs (activevideo, y_px, vsync) in the pixel-clock domain.
// - Prefetches the displayed cell row into row_data once per cell row, using horizontal blanking.
// - Emits frame_tick so the engine can start one generation per frame.

---
 rtl/ca_pkg.sv | 22 ++
 rtl/ca_edge_det.sv | 32 +++
 rtl/ca_row_mem_sched.sv | 156 +++++++++++++++
 tb/tb_ca_row_mem_sched.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ca_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ca_pkg
// Purpose  : Shared state encoding and default geometry for the CA row scheduler.
// Revision : 1.0  initial release
// ============================================================================
package ca_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DISP = 2'd1,
        S_ENG  = 2'd2
    } state_t;

    localparam int c_WIDTH      = 80;
    localparam int c_ROWS       = 60;
    localparam int c_AW         = 6;
    localparam int c_CELL_SHIFT = 3;
    localparam int c_V_ACTIVE   = 480;

endpackage
`default_nettype wire

// File: rtl/ca_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : ca_edge_det
// Purpose  : Rise/fall detector on a registered copy of the input; RST_VAL sets
//            the assumed previous level so nothing fires right after reset.
// Revision : 1.0  initial release
// ============================================================================
module ca_edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= RST_VAL;
        end else begin
            r_prev <= din;
        end
    end

    assign rise = din & ~r_prev;
    assign fall = ~din & r_prev;

endmodule
`default_nettype wire

// File: rtl/ca_row_mem_sched.sv
`default_nettype none
// ============================================================================
// Module   : ca_row_mem_sched
// Purpose  : Single-port row-RAM scheduler; display row prefetch beats the
//            engine. Macro TEARFREE_EN limits engine writes to vertical blank.
// Revision : 1.0  initial release
// ============================================================================
module ca_row_mem_sched
    import ca_pkg::*;
#(
    parameter int WIDTH      = c_WIDTH,
    parameter int ROWS       = c_ROWS,
    parameter int AW         = c_AW,
    parameter int CELL_SHIFT = c_CELL_SHIFT,
    parameter int V_ACTIVE   = c_V_ACTIVE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             activevideo,
    input  logic             vsync,
    input  logic [9:0]       y_px,
    output logic [WIDTH-1:0] row_data,
    output logic             frame_tick,
    input  logic             eng_req,
    input  logic             eng_we,
    input  logic [AW-1:0]    eng_addr,
    input  logic [WIDTH-1:0] eng_wdata,
    output logic             eng_gnt,
    output logic             eng_rvalid,
    output logic [WIDTH-1:0] eng_rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    state_t          r_state;
    logic            r_disp_pend;
    logic [AW-1:0]   r_disp_row;
    logic            r_eng_oor;

    logic            w_vs_rise;
    logic            w_vs_fall;
    logic            w_av_rise;
    logic            w_av_fall;
    logic [10:0]     w_next_row;
    logic            w_line_evt;
    logic            w_evt;
    logic            w_addr_ok;
    logic            w_wr_ok;
    logic            w_unused;

    ca_edge_det #(.RST_VAL(1'b1)) u_vsync_det (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (vsync),
        .rise (w_vs_rise),
        .fall (w_vs_fall)
    );

    ca_edge_det #(.RST_VAL(1'b0)) u_active_det (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (activevideo),
        .rise (w_av_rise),
        .fall (w_av_fall)
    );

    // Prefetch the next cell row on the last pixel line of the current one.
    assign w_next_row = {1'b0, y_px >> CELL_SHIFT} + 11'd1;
    assign w_line_evt = w_av_fall && (&y_px[CELL_SHIFT-1:0]) && (w_next_row < 11'(ROWS));
    assign w_evt      = w_vs_fall || w_line_evt;
    assign w_addr_ok  = ({1'b0, eng_addr} < (AW+1)'(ROWS));

`ifdef TEARFREE_EN
    logic r_in_vblank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_vblank <= 1'b1;
        end else if (w_av_fall && (y_px == 10'(V_ACTIVE - 1))) begin
            r_in_vblank <= 1'b1;
        end else if (w_av_rise) begin
            r_in_vblank <= 1'b0;
        end
    end

    assign w_wr_ok  = r_in_vblank;
    assign w_unused = w_vs_rise;
`else
    assign w_wr_ok  = 1'b1;
    assign w_unused = w_vs_rise ^ w_av_rise;
`endif

    // The port is free whenever no access is issued this cycle, so the same
    // issue rules apply in every state; the state only tags returning data.
    always_comb begin
        eng_gnt   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (r_disp_pend) begin
            mem_en   = 1'b1;
            mem_addr = r_disp_row;
        end else if (eng_req && !w_evt && (!eng_we || w_wr_ok)) begin
            eng_gnt   = 1'b1;
            mem_en    = w_addr_ok;
            mem_we    = eng_we && w_addr_ok;
            mem_addr  = eng_addr;
            mem_wdata = eng_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_disp_pend <= 1'b0;
            r_disp_row  <= '0;
            r_eng_oor   <= 1'b0;
            row_data    <= '0;
            frame_tick  <= 1'b0;
        end else begin
            frame_tick <= w_vs_fall;

            if (w_vs_fall) begin
                r_disp_pend <= 1'b1;
                r_disp_row  <= '0;
            end else if (w_line_evt) begin
                r_disp_pend <= 1'b1;
                r_disp_row  <= w_next_row[AW-1:0];
            end else if (r_disp_pend) begin
                r_disp_pend <= 1'b0;
            end

            if (r_state == S_DISP) begin
                row_data <= mem_rdata;
            end

            if (r_disp_pend) begin
                r_state <= S_DISP;
            end else if (eng_gnt && !eng_we) begin
                r_state   <= S_ENG;
                r_eng_oor <= !w_addr_ok;
            end else begin
                r_state <= S_IDLE;
            end
        end
    end

    assign eng_rvalid = (r_state == S_ENG);
    assign eng_rdata  = ((r_state == S_ENG) && !r_eng_oor) ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_ca_row_mem_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ca_row_mem_sched
// Purpose  : Self-checking bench for ca_row_mem_sched with a shadow-RAM model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ca_row_mem_sched;

    localparam int WIDTH    = 80;
    localparam int ROWS     = 60;
    localparam int AW       = 6;
    localparam int V_ACTIVE = 480;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             activevideo;
    logic             vsync;
    logic [9:0]       y_px;
    logic [WIDTH-1:0] row_data;
    logic             frame_tick;
    logic             eng_req;
    logic             eng_we;
    logic [AW-1:0]    eng_addr;
    logic [WIDTH-1:0] eng_wdata;
    logic             eng_gnt;
    logic             eng_rvalid;
    logic [WIDTH-1:0] eng_rdata;
    logic             mem_en;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    ca_row_mem_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .activevideo(activevideo),
        .vsync      (vsync),
        .y_px       (y_px),
        .row_data   (row_data),
        .frame_tick (frame_tick),
        .eng_req    (eng_req),
        .eng_we     (eng_we),
        .eng_addr   (eng_addr),
        .eng_wdata  (eng_wdata),
        .eng_gnt    (eng_gnt),
        .eng_rvalid (eng_rvalid),
        .eng_rdata  (eng_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Single-port RAM with one cycle of read latency.
    logic [WIDTH-1:0] env_ram [64];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) env_ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= env_ram[mem_addr];
        end
    end

    // Reference model: what each row should hold and what row_data should show.
    logic [WIDTH-1:0] ref_ram [ROWS];
    logic [WIDTH-1:0] exp_row  = '0;
    bit               m_vblank = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[WIDTH-1:0];
    endfunction

    task automatic quiet_cycles(input string tag, input int n);
        int busy;
        busy = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (mem_en || frame_tick) busy++;
        end
        check_val(tag, busy, 0);
    endtask

    // One engine access, held until granted; checks port drive and read return.
    task automatic eng_op(input bit we, input int addr, input logic [WIDTH-1:0] wd);
        int               lat;
        bit               in_rng;
        logic [WIDTH-1:0] exp_rd;
        in_rng = (addr < ROWS);
        exp_rd = '0;
        if (in_rng) exp_rd = ref_ram[addr];
        lat = -1;
        @(posedge clk); #1;
        eng_req = 1'b1; eng_we = we; eng_addr = AW'(addr); eng_wdata = wd;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (eng_gnt) begin
                lat = i;
                check_val("eng_mem_en", mem_en, in_rng);
                check_val("eng_mem_we", mem_we, we && in_rng);
                if (in_rng) check_val("eng_mem_addr", mem_addr, addr);
                if (we && in_rng) check_val("eng_mem_wdata", mem_wdata, wd);
            end
            @(posedge clk); #1;
            if (lat >= 0) break;
        end
        eng_req = 1'b0;
        check_val("eng_gnt_lat", lat, 0);
        if (lat >= 0 && we && in_rng) ref_ram[addr] = wd;
        if (lat >= 0 && !we) begin
            @(negedge clk);
            check_val("eng_rvalid", eng_rvalid, 1);
            check_val("eng_rdata", eng_rdata, exp_rd);
        end
    endtask

    // Display event (frame or line), optionally colliding with an engine read.
    task automatic disp_event(input bit frame, input int y, input int eaddr);
        bit               fetch;
        int               row, rd_at, gnt_at, rv_at, ft_cnt;
        logic [AW-1:0]    rd_addr, g_addr;
        logic             g_en;
        logic [WIDTH-1:0] rv_data, exp_rd;
        rd_at = -1; gnt_at = -1; rv_at = -1; ft_cnt = 0;
        rd_addr = '0; g_addr = '0; g_en = 1'b0; rv_data = '0; exp_rd = '0;
        if (frame) begin
            fetch = 1'b1; row = 0;
        end else begin
            row   = y / 8 + 1;
            fetch = (y % 8 == 7) && (row < ROWS);
        end
        if (eaddr >= 0 && eaddr < ROWS) exp_rd = ref_ram[eaddr];
        @(posedge clk); #1;
        if (frame) begin
            vsync = 1'b0;
        end else begin
            y_px = 10'(y); activevideo = 1'b1; m_vblank = 1'b0;
            @(posedge clk); #1;
            activevideo = 1'b0;
            if (y == V_ACTIVE - 1) m_vblank = 1'b1;
        end
        if (eaddr >= 0) begin
            eng_req = 1'b1; eng_we = 1'b0; eng_addr = AW'(eaddr);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (frame_tick) ft_cnt++;
            if (eng_gnt && gnt_at < 0) begin
                gnt_at = c; g_addr = mem_addr; g_en = mem_en;
            end else if (mem_en && !mem_we && rd_at < 0) begin
                rd_at = c; rd_addr = mem_addr;
            end
            if (eng_rvalid && rv_at < 0) begin
                rv_at = c; rv_data = eng_rdata;
            end
            @(posedge clk); #1;
            if (gnt_at == c) eng_req = 1'b0;
        end
        eng_req = 1'b0;
        vsync   = 1'b1;
        if (fetch) exp_row = ref_ram[row];
        check_val("frame_tick_cnt", ft_cnt, frame ? 1 : 0);
        if (fetch) begin
            check_val("fetch_in_time", (rd_at >= 1 && rd_at <= 2), 1);
            check_val("fetch_addr", rd_addr, row);
        end else begin
            check_val("no_fetch", (rd_at < 0), 1);
        end
        if (eaddr >= 0) begin
            check_val("coll_gnt_after_disp", gnt_at, rd_at + 1);
            check_val("coll_gnt_addr", g_addr, eaddr);
            check_val("coll_gnt_en", g_en, eaddr < ROWS);
            check_val("coll_rvalid_lat", rv_at, gnt_at + 1);
            check_val("coll_rdata", rv_data, exp_rd);
        end
        check_val("row_data", row_data, exp_row);
    endtask

`ifdef TEARFREE_EN
    task automatic tearfree_test();
        int               lat;
        logic [WIDTH-1:0] w;
        w = rand_word();
        @(posedge clk); #1;
        y_px = 10'd100; activevideo = 1'b1; m_vblank = 1'b0;
        @(posedge clk); #1;
        eng_req = 1'b1; eng_we = 1'b1; eng_addr = 6'd9; eng_wdata = w;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("tf_wr_held", eng_gnt, 0);
            @(posedge clk); #1;
        end
        eng_we = 1'b0;
        @(negedge clk);
        check_val("tf_rd_gnt", eng_gnt, 1);
        @(posedge clk); #1;
        eng_we = 1'b1;
        @(negedge clk);
        check_val("tf_rd_rvalid", eng_rvalid, 1);
        check_val("tf_rd_rdata", eng_rdata, ref_ram[9]);
        check_val("tf_wr_still_held", eng_gnt, 0);
        @(posedge clk); #1;
        y_px = 10'(V_ACTIVE - 1); activevideo = 1'b0; m_vblank = 1'b1;
        lat = -1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (eng_gnt && lat < 0) lat = i;
            @(posedge clk); #1;
            if (lat >= 0) eng_req = 1'b0;
        end
        eng_req = 1'b0;
        check_val("tf_wr_after_vblank", (lat >= 0 && lat <= 1), 1);
        if (lat >= 0) ref_ram[9] = w;
    endtask
`endif

    initial begin
        int op, y, a;
        vsync = 1'b1; activevideo = 1'b0; y_px = '0;
        eng_req = 1'b0; eng_we = 1'b0; eng_addr = '0; eng_wdata = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_row_data", row_data, 0);
        check_val("rst_frame_tick", frame_tick, 0);
        check_val("rst_rvalid", eng_rvalid, 0);
        check_val("rst_rdata", eng_rdata, 0);
        check_val("rst_mem_en", mem_en, 0);
        check_val("rst_mem_we", mem_we, 0);
        check_val("rst_gnt", eng_gnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        quiet_cycles("post_rst_quiet", 4);

        for (int r = 0; r < ROWS; r++) eng_op(1'b1, r, rand_word());

        disp_event(1'b1, 0, -1);
        disp_event(1'b0, 7, -1);
        disp_event(1'b0, 6, -1);
        disp_event(1'b0, V_ACTIVE - 1, -1);
        disp_event(1'b0, 15, 5);
        eng_op(1'b0, 63, '0);
        eng_op(1'b1, 62, rand_word());
        eng_op(1'b0, 5, '0);
`ifdef TEARFREE_EN
        tearfree_test();
`endif

        for (int n = 0; n < 150; n++) begin
            op = int'($urandom_range(0, 5));
            case (op)
                0, 1: begin
`ifdef TEARFREE_EN
                    if (!m_vblank) disp_event(1'b0, V_ACTIVE - 1, -1);
`endif
                    eng_op(1'b1, int'($urandom_range(0, 63)), rand_word());
                end
                2: eng_op(1'b0, int'($urandom_range(0, 63)), '0);
                3: begin
                    if ($urandom_range(0, 1) == 1) y = int'($urandom_range(0, ROWS - 1)) * 8 + 7;
                    else                           y = int'($urandom_range(0, V_ACTIVE - 1));
                    disp_event(1'b0, y, -1);
                end
                4: disp_event(1'b1, 0, -1);
                default: begin
                    y = int'($urandom_range(0, ROWS - 2)) * 8 + 7;
                    a = int'($urandom_range(0, 63));
                    disp_event(1'b0, y, a);
                end
            endcase
        end

        // Reset while a read is returning.
        @(posedge clk); #1;
        eng_req = 1'b1; eng_we = 1'b0; eng_addr = 6'd10;
        @(negedge clk);
        check_val("mid_rst_gnt", eng_gnt, 1);
        @(posedge clk); #1;
        eng_req = 1'b0;
        @(negedge clk);
        check_val("mid_rst_pre_rvalid", eng_rvalid, 1);
        #1 rst_n = 1'b0;
        exp_row = '0;
        @(negedge clk);
        check_val("mid_rst_row_data", row_data, 0);
        check_val("mid_rst_rvalid", eng_rvalid, 0);
        check_val("mid_rst_rdata", eng_rdata, 0);
        check_val("mid_rst_mem_en", mem_en, 0);
        check_val("mid_rst_frame_tick", frame_tick, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_vblank = 1'b1;
        quiet_cycles("mid_rst_quiet", 4);
        disp_event(1'b1, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
